muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter MUL_STAGES, default 2: number of cycles from multiply start to done (legal range 1..4).
REQ-002 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2: operation select, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port src_a  input  32: multiplicand or dividend (rs).
REQ-007 SHALL have port src_b  input  32: multiplier or divisor (rt).
REQ-008 SHALL have port flush  input  1: abort the in-flight operation (exception or branch flush).
REQ-009 SHALL have port busy  output  1: operation in progress; the pipeline stalls on it.
REQ-010 SHALL have port hl_write_enable  output  1: one-cycle result-valid pulse, forwarded to the register-file hi/lo write enable.
REQ-011 SHALL have port hl_data  output  64: result, [63:32] to hi and [31:0] to lo.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL, in IDLE with start=1 and flush=0, register src_a, src_b and op, and go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-014 SHALL ignore start in any state other than IDLE; operands are captured once only.
REQ-015 SHALL assert busy in the MUL and DIV states and deassert it in IDLE and DONE.
REQ-016 SHALL produce the multiply result as the full 64-bit product: two's-complement for MULT, unsigned for MULTU.
REQ-017 SHALL, for multiply, reach DONE exactly MUL_STAGES cycles after the start edge.
REQ-018 SHALL divide as radix-2 restoring on absolute values, one quotient bit per cycle, 32 iterations.
REQ-019 SHALL, for DIV and DIVU, reach DONE 34 cycles after the start edge: 1 setup cycle, 32 iterations, 1 sign fix-up cycle.
REQ-020 SHALL apply DIV signs as follows: the quotient is negated when the operand signs differ, and the remainder takes the dividend's sign.
REQ-021 SHALL place the division result as hl_data[31:0]=quotient and hl_data[63:32]=remainder.
REQ-022 SHALL, on divide-by-zero (src_b=0), reach DONE on the next cycle with lo=32'hFFFFFFFF and hi=src_a, for both DIV and DIVU.
REQ-023 SHALL pulse hl_write_enable for exactly one cycle in DONE, then return to IDLE.
REQ-024 SHALL hold hl_data stable from DONE until the next accepted start.
REQ-025 SHALL, on flush in MUL or DIV, return to IDLE on the next edge without asserting hl_write_enable.
REQ-026 SHALL, on flush in DONE, suppress hl_write_enable in that cycle.
REQ-027 SHALL resolve flush and start in the same IDLE cycle in favour of flush; start is dropped.
REQ-028 SHALL accept a new start in the IDLE cycle that follows DONE; there is no back-to-back start out of DONE.

Reset
REQ-029 SHALL, while rst is high, force state=IDLE, busy=0, hl_write_enable=0, hl_data=64'h0 and clear all internal registers, asynchronously.
REQ-030 SHALL abandon any in-flight operation on rst assertion without producing a write.

Configuration
REQ-031 SHALL, with MULDIV_DIV_EN defined, include the divider datapath as specified above.
REQ-032 SHALL, without MULDIV_DIV_EN, omit the divider: DIV and DIVU reach DONE on the next cycle with hl_data=64'h0 and hl_write_enable pulsed, and multiply behaviour is unchanged.

Structure
REQ-033 SHALL place the op encodings (OP_MULT..OP_DIVU), the state encoding and the constant DIV_ITER=32 in shared package muldiv_pkg.
REQ-034 SHALL implement the divider as sub-module muldiv_div_core (unsigned iterative core with start/done); sign handling stays in muldiv_unit.
REQ-035 SHALL use no latches and keep the multiplier pipeline as MUL_STAGES registered stages.

Verification
REQ-036 SHALL cover: MULT src_a=32'hFFFFFFFD (-3), src_b=5, MUL_STAGES=2 -> hl_write_enable at cycle +2, hl_data=64'hFFFFFFFF_FFFFFFF1.
REQ-037 SHALL cover: DIVU 100/7 -> busy for 34 cycles, hl_data={32'd2,32'd14}.
REQ-038 SHALL cover: DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; and DIV 7/-2 -> lo=32'hFFFFFFFD, hi=32'h1.
REQ-039 SHALL cover: DIV 5/0 -> done at cycle +1, lo=32'hFFFFFFFF, hi=32'h5.
REQ-040 SHALL cover: flush at cycle 10 of DIVU -> no hl_write_enable, busy=0 next cycle, a following MULTU 3*4 -> hl_data=64'hC.
REQ-041 SHALL cover: rst asserted mid-DIV between clock edges -> busy=0 and hl_data=0 immediately, with no write pulse after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the multiply/divide unit.
//
// Contents:
//   op_t      operation select encoding (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
//   state_t   control FSM states of muldiv_unit
//   DIV_ITER  number of restoring-division iterations (one quotient bit each)
//   negate_if two's-complement negation helper used by the divider sign fix-up
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int DIV_ITER = 32;

    // Returns -value when neg is set, value otherwise.
    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] value);
        return neg ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core -- unsigned radix-2 restoring divider.
//
// A start pulse loads the operands; the core then produces one quotient bit
// per clock for DIV_ITER clocks and raises done, holding quotient/remainder
// until the next start. A new start always restarts the core, even if it is
// still running, so an aborted operation needs no separate cancel.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                load dividend/divisor and begin iterating
//   dividend, divisor    unsigned 32-bit operands (divisor assumed non-zero)
//   done                 set after the last iteration, cleared by start
//   quotient, remainder  unsigned 32-bit results, valid while done is set
module muldiv_div_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] ITER_LAST = 5'(DIV_ITER - 1);

    logic [31:0] divisor_q;
    logic [4:0]  iter;
    logic        running;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;

    // The quotient register doubles as the dividend shift register: each step
    // moves its top bit into the partial remainder and shifts a result bit in.
    assign shifted = {remainder, quotient[31]};
    assign fits    = shifted >= {1'b0, divisor_q};
    // The true difference is below the divisor whenever fits is set, so the
    // low 32 bits are exact.
    assign diff    = shifted[31:0] - divisor_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor_q <= '0;
            iter      <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            divisor_q <= divisor;
            quotient  <= dividend;
            remainder <= '0;
            iter      <= '0;
            running   <= 1'b1;
            done      <= 1'b0;
        end else if (running) begin
            if (fits) begin
                remainder <= diff;
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= shifted[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            iter <= iter + 5'd1;
            if (iter == ITER_LAST) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- MIPS-style hi/lo multiply/divide unit.
//
// Multiplies (MULT/MULTU) go through a MUL_STAGES-deep registered pipeline.
// Divides (DIV/DIVU) use the iterative unsigned core muldiv_div_core on
// absolute values, with signs applied here in a final fix-up cycle.
// Divide-by-zero finishes after one cycle with lo=all ones, hi=dividend.
//
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// DIV/DIVU complete after one cycle with a zero result.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, op         request and operation select, sampled only in IDLE
//   src_a, src_b      rs / rt operands, captured once at start
//   flush             abort the in-flight operation / suppress its write
//   busy              high while multiplying or dividing
//   hl_write_enable   one-cycle result-valid pulse for the hi/lo registers
//   hl_data           result, [63:32] -> hi, [31:0] -> lo; held until next start
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        hl_write_enable,
    output logic [63:0] hl_data
);

    localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES - 1);

    state_t      state;
    op_t         op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  mul_cnt;
    logic        div_setup;
    logic        write_q;

    logic        mul_signed;
    logic [63:0] mul_ext_a;
    logic [63:0] mul_ext_b;
    logic [63:0] mul_product;
    logic [63:0] mul_tail;

    // Sign- or zero-extending to 64 bits lets one truncated 64-bit product
    // serve both MULT and MULTU.
    assign mul_signed  = (op_q == OP_MULT);
    assign mul_ext_a   = {{32{mul_signed & a_q[31]}}, a_q};
    assign mul_ext_b   = {{32{mul_signed & b_q[31]}}, b_q};
    assign mul_product = mul_ext_a * mul_ext_b;

    // The result register is the last multiplier stage, so MUL_STAGES-1
    // intermediate registers sit between the captured operands and hl_data.
    generate
        if (MUL_STAGES == 1) begin : g_mul_direct
            assign mul_tail = mul_product;
        end else begin : g_mul_pipe
            logic [63:0] stage [MUL_STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_STAGES - 1; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= mul_product;
                    for (int i = 1; i < MUL_STAGES - 1; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign mul_tail = stage[MUL_STAGES-2];
        end
    endgenerate

`ifdef MULDIV_DIV_EN
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic        core_start;
    logic        core_done;
    logic [31:0] core_quotient;
    logic [31:0] core_remainder;
    logic [63:0] div_result;

    // The core sees magnitudes only. The quotient is negative when the
    // operand signs differ; the remainder follows the dividend.
    assign div_signed = (op_q == OP_DIV);
    assign a_neg      = div_signed & a_q[31];
    assign b_neg      = div_signed & b_q[31];
    assign core_start = (state == ST_DIV) && div_setup && (b_q != 32'd0);
    assign div_result = {negate_if(a_neg, core_remainder),
                         negate_if(a_neg ^ b_neg, core_quotient)};

    muldiv_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .dividend  (negate_if(a_neg, a_q)),
        .divisor   (negate_if(b_neg, b_q)),
        .done      (core_done),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );
`endif

    // Control FSM. A divide spends its first DIV cycle on setup (loading the
    // core, or finishing at once on a zero divisor), then waits for the core
    // and applies signs on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            mul_cnt   <= '0;
            div_setup <= 1'b0;
            busy      <= 1'b0;
            write_q   <= 1'b0;
            hl_data   <= '0;
        end else begin
            write_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q      <= op_t'(op);
                        a_q       <= src_a;
                        b_q       <= src_b;
                        mul_cnt   <= '0;
                        div_setup <= 1'b1;
                        busy      <= 1'b1;
                        state     <= op[1] ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (mul_cnt == MUL_LAST) begin
                        hl_data <= mul_tail;
                        write_q <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        mul_cnt <= mul_cnt + 3'd1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (div_setup) begin
                        div_setup <= 1'b0;
`ifdef MULDIV_DIV_EN
                        if (b_q == 32'd0) begin
                            hl_data <= {a_q, 32'hFFFF_FFFF};
                            write_q <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_DONE;
                        end
`else
                        hl_data <= '0;
                        write_q <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
`endif
                    end
`ifdef MULDIV_DIV_EN
                    else if (core_done) begin
                        hl_data <= div_result;
                        write_q <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The pulse is registered, but a flush arriving during DONE has to kill
    // the write within the same cycle, hence the combinational gate.
    assign hl_write_enable = write_q & ~flush;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit.
//
// Directed corner cases plus randomized operations, each checked against a
// plain-arithmetic reference model for result and latency. Expectations for
// divides follow the MULDIV_DIV_EN build option.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int MUL_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        hl_write_enable;
    logic [63:0] hl_data;

    int checks_total  = 0;
    int checks_passed = 0;

    muldiv_unit #(.MUL_STAGES(MUL_STAGES)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .op              (op),
        .src_a           (src_a),
        .src_b           (src_b),
        .flush           (flush),
        .busy            (busy),
        .hl_write_enable (hl_write_enable),
        .hl_data         (hl_data)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference result: MIPS hi/lo semantics written with plain arithmetic.
    function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00:   return 64'(sa * sb);
            2'b01:   return {32'h0, a} * {32'h0, b};
            default: begin
`ifdef MULDIV_DIV_EN
                logic [63:0] q;
                logic [63:0] r;
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'b11) begin
                    sa = longint'({32'h0, a});
                    sb = longint'({32'h0, b});
                end
                q = 64'(sa / sb);
                r = 64'(sa % sb);
                return {r[31:0], q[31:0]};
`else
                return 64'h0;
`endif
            end
        endcase
    endfunction

    // Reference latency in clock edges from the start edge to the write.
    function automatic int model_latency(input logic [1:0] o, input logic [31:0] b);
        if (!o[1]) return MUL_STAGES;
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) return 1;
        return 34;
`else
        return 1;
`endif
    endfunction

    // Runs one operation, scrambling the inputs after the start edge, and
    // checks latency, busy duration, result, pulse width and result hold.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input string tag);
        int          lat;
        int          busy_cycles;
        int          exp_lat;
        logic [63:0] exp;
        exp     = model_result(o, a, b);
        exp_lat = model_latency(o, b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        src_a = $urandom;
        src_b = $urandom;
        lat         = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 200; k++) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            if (hl_write_enable) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, " busy cycles"}, 64'(busy_cycles), 64'(exp_lat));
        checkOutput({tag, " data"}, hl_data, exp);
        checkOutput({tag, " busy in done"}, {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        checkOutput({tag, " single pulse"}, {63'h0, hl_write_enable}, 64'h0);
        checkOutput({tag, " data hold"}, hl_data, exp);
    endtask

    // Starts an operation and flushes it so the flush is seen on edge fe.
    task automatic flushTest(input logic [1:0] o, input int fe, input string tag);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = 32'd100;
        src_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k < fe; k++) begin
            @(posedge clk);
            #1;
            if (hl_write_enable) seen = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput({tag, " busy after flush"}, {63'h0, busy}, 64'h0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (hl_write_enable) seen = 1'b1;
        end
        checkOutput({tag, " no write"}, {63'h0, seen}, 64'h0);
    endtask

    initial begin
        logic        seen;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          fe;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        #2;
        checkOutput("reset busy", {63'h0, busy}, 64'h0);
        checkOutput("reset write", {63'h0, hl_write_enable}, 64'h0);
        checkOutput("reset data", hl_data, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");

        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, "MULT -3*5");
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULTU max*max");
        applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, "MULT min*min");
        applyStimulus(2'b11, 32'd100, 32'd7, "DIVU 100/7");
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
        applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE, "DIV 7/-2");
        applyStimulus(2'b10, 32'd5, 32'd0, "DIV 5/0");
        applyStimulus(2'b11, 32'hDEAD_BEEF, 32'd0, "DIVU x/0");
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "DIV min/-1");

`ifdef MULDIV_DIV_EN
        fe = 10;
`else
        fe = 1;
`endif
        flushTest(2'b11, fe, "flush DIVU");
        applyStimulus(2'b01, 32'd3, 32'd4, "MULTU 3*4 after flush");
        flushTest(2'b00, 1, "flush MULT");

        // Flush raised during DONE must cancel that cycle's write.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd6;
        src_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (MUL_STAGES) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        checkOutput("flush in DONE write", {63'h0, hl_write_enable}, 64'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush in DONE busy", {63'h0, busy}, 64'h0);
        checkOutput("flush in DONE no late write", {63'h0, hl_write_enable}, 64'h0);

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b01;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("start+flush busy", {63'h0, busy}, 64'h0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (hl_write_enable) seen = 1'b1;
        end
        checkOutput("start+flush no write", {63'h0, seen}, 64'h0);

        for (int n = 0; n < 20; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else rb = $urandom_range(1, 20);
            applyStimulus(ro, ra, rb, $sformatf("random %0d op%0d", n, ro));
        end

        applyStimulus(2'b01, 32'd9, 32'd9, "MULTU before reset");

        // Reset raised between edges of an in-flight operation.
        @(negedge clk);
        start = 1'b1;
`ifdef MULDIV_DIV_EN
        op = 2'b10;
        fe = 5;
`else
        op = 2'b00;
        fe = 0;
`endif
        src_a = 32'd1000;
        src_b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (fe) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async reset busy", {63'h0, busy}, 64'h0);
        checkOutput("async reset data", hl_data, 64'h0);
        checkOutput("async reset write", {63'h0, hl_write_enable}, 64'h0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (hl_write_enable || busy) seen = 1'b1;
        end
        checkOutput("no activity after reset", {63'h0, seen}, 64'h0);
        applyStimulus(2'b11, 32'd100, 32'd7, "DIVU after reset");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
